// File: rtl/flash_read_arbiter.sv
// Arbitrates the single QSPI flash read port between the CPU and the ADPCM audio fetcher.
// Audio wins contention until a streak limit forces one CPU grant through.
module flash_read_arbiter #(
  parameter int unsigned ADDR_WIDTH       = 24,
  parameter int unsigned AUDIO_STREAK_MAX = 3
) (
  input  logic                  clk_2x,
  input  logic                  reset_2x,
  input  logic                  cpu_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  input  logic                  audio_valid,
  input  logic [ADDR_WIDTH-1:0] audio_address,
  output logic                  audio_ready,
  output logic [31:0]           audio_rdata,
  output logic                  flash_valid,
  output logic [ADDR_WIDTH-1:0] flash_address,
  input  logic                  flash_ready,
  input  logic [31:0]           flash_rdata,
  output logic                  grant_audio,
  output logic                  busy
);

  localparam logic [3:0] StreakMax = 4'(AUDIO_STREAK_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StRespond} state_e;

  state_e                r_state;
  logic [3:0]            r_streak;
  logic                  r_flash_valid;
  logic [ADDR_WIDTH-1:0] r_flash_address;
  logic                  r_cpu_ready;
  logic [31:0]           r_cpu_rdata;
  logic                  r_audio_ready;
  logic [31:0]           r_audio_rdata;
  logic                  r_grant_audio;
  logic                  r_busy;

  logic w_any_req;
  logic w_pick_audio;

  assign w_any_req    = cpu_valid | audio_valid;
  // Under contention audio wins unless it has already used up its streak.
  assign w_pick_audio = audio_valid & (~cpu_valid | (r_streak != StreakMax));

  always_ff @(posedge clk_2x) begin
    if (reset_2x) begin
      r_state         <= StIdle;
      r_streak        <= 4'd0;
      r_flash_valid   <= 1'b0;
      r_flash_address <= '0;
      r_cpu_ready     <= 1'b0;
      r_cpu_rdata     <= 32'd0;
      r_audio_ready   <= 1'b0;
      r_audio_rdata   <= 32'd0;
      r_grant_audio   <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state         <= StIssue;
            r_busy          <= 1'b1;
            r_flash_valid   <= 1'b1;
            r_grant_audio   <= w_pick_audio;
            r_flash_address <= w_pick_audio ? audio_address : cpu_address;
            if (!w_pick_audio) begin
              r_streak <= 4'd0;
            end else if (cpu_valid && (r_streak != StreakMax)) begin
              r_streak <= r_streak + 4'd1;
            end
          end
        end
        StIssue: begin
          if (flash_ready) begin
            r_state       <= StRespond;
            r_flash_valid <= 1'b0;
            if (r_grant_audio) begin
              r_audio_rdata <= flash_rdata;
              r_audio_ready <= 1'b1;
            end else begin
              r_cpu_rdata <= flash_rdata;
              r_cpu_ready <= 1'b1;
            end
          end
        end
        StRespond: begin
          r_state       <= StIdle;
          r_busy        <= 1'b0;
          r_cpu_ready   <= 1'b0;
          r_audio_ready <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign flash_valid   = r_flash_valid;
  assign flash_address = r_flash_address;
  assign cpu_ready     = r_cpu_ready;
  assign cpu_rdata     = r_cpu_rdata;
  assign audio_ready   = r_audio_ready;
  assign audio_rdata   = r_audio_rdata;
  assign grant_audio   = r_grant_audio;
  assign busy          = r_busy;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: a table of read transactions with hand-computed
// grants and data, plus a hand-written reset-during-read sequence.
module tb_flash_read_arbiter;

  localparam int AW = 24;

  logic          clk_2x = 1'b0;
  logic          reset_2x;
  logic          cpu_valid;
  logic [AW-1:0] cpu_address;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          audio_valid;
  logic [AW-1:0] audio_address;
  logic          audio_ready;
  logic [31:0]   audio_rdata;
  logic          flash_valid;
  logic [AW-1:0] flash_address;
  logic          flash_ready;
  logic [31:0]   flash_rdata;
  logic          grant_audio;
  logic          busy;

  always #5 clk_2x = ~clk_2x;

  flash_read_arbiter #(
    .ADDR_WIDTH       (AW),
    .AUDIO_STREAK_MAX (3)
  ) dut (
    .clk_2x        (clk_2x),
    .reset_2x      (reset_2x),
    .cpu_valid     (cpu_valid),
    .cpu_address   (cpu_address),
    .cpu_ready     (cpu_ready),
    .cpu_rdata     (cpu_rdata),
    .audio_valid   (audio_valid),
    .audio_address (audio_address),
    .audio_ready   (audio_ready),
    .audio_rdata   (audio_rdata),
    .flash_valid   (flash_valid),
    .flash_address (flash_address),
    .flash_ready   (flash_ready),
    .flash_rdata   (flash_rdata),
    .grant_audio   (grant_audio),
    .busy          (busy)
  );

  typedef struct {
    logic          cv;
    logic          av;
    logic [AW-1:0] ca;
    logic [AW-1:0] aa;
    int            lat;
    logic [31:0]   data;
    logic          exp_aud;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_crd;
  logic [31:0] exp_ard;

  task automatic tick();
    @(posedge clk_2x);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic av, input logic [AW-1:0] ca,
                     input logic [AW-1:0] aa, input int lat, input logic [31:0] data,
                     input logic exp_aud);
    vec_t v;
    v.cv = cv; v.av = av; v.ca = ca; v.aa = aa;
    v.lat = lat; v.data = data; v.exp_aud = exp_aud;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " flash_valid"}, {31'd0, flash_valid}, 32'd0);
    chk({tag, " flash_address"}, {8'd0, flash_address}, 32'd0);
    chk({tag, " cpu_ready"}, {31'd0, cpu_ready}, 32'd0);
    chk({tag, " audio_ready"}, {31'd0, audio_ready}, 32'd0);
    chk({tag, " grant_audio"}, {31'd0, grant_audio}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, " audio_rdata"}, audio_rdata, 32'd0);
  endtask

  // Starts in an IDLE cycle, ends in the following IDLE cycle; the flash model answers
  // in cycle v.lat after the grant edge.
  task automatic run_txn(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    cpu_valid     = v.cv;
    audio_valid   = v.av;
    cpu_address   = v.ca;
    audio_address = v.aa;
    tick();
    chk({p, " grant_audio"}, {31'd0, grant_audio}, {31'd0, v.exp_aud});
    chk({p, " flash_address"}, {8'd0, flash_address}, {8'd0, v.exp_aud ? v.aa : v.ca});
    for (int c = 1; c <= v.lat; c++) begin
      chk({p, $sformatf(" flash_valid c%0d", c)}, {31'd0, flash_valid}, 32'd1);
      chk({p, $sformatf(" busy c%0d", c)}, {31'd0, busy}, 32'd1);
      chk({p, $sformatf(" readies c%0d", c)}, {30'd0, cpu_ready, audio_ready}, 32'd0);
      if (c == v.lat) begin
        flash_ready = 1'b1;
        flash_rdata = v.data;
      end
      tick();
    end
    flash_ready = 1'b0;
    flash_rdata = 32'd0;
    if (v.exp_aud) exp_ard = v.data;
    else           exp_crd = v.data;
    chk({p, " cpu_ready"}, {31'd0, cpu_ready}, {31'd0, ~v.exp_aud});
    chk({p, " audio_ready"}, {31'd0, audio_ready}, {31'd0, v.exp_aud});
    chk({p, " cpu_rdata"}, cpu_rdata, exp_crd);
    chk({p, " audio_rdata"}, audio_rdata, exp_ard);
    chk({p, " flash_valid resp"}, {31'd0, flash_valid}, 32'd0);
    tick();
    chk({p, " busy idle"}, {31'd0, busy}, 32'd0);
    chk({p, " readies idle"}, {30'd0, cpu_ready, audio_ready}, 32'd0);
    chk({p, " grant held"}, {31'd0, grant_audio}, {31'd0, v.exp_aud});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t h;
    reset_2x = 1'b1; cpu_valid = 1'b0; audio_valid = 1'b0;
    cpu_address = '0; audio_address = '0; flash_ready = 1'b0; flash_rdata = 32'd0;
    exp_crd = 32'd0; exp_ard = 32'd0;

    // CPU-only read
    add(1, 0, 24'h100000, 24'h000000, 5, 32'hDEADBEEF, 0);
    // Continuous contention: A,A,A,C,A,A,A,C
    add(1, 1, 24'h100100, 24'h200000, 2, 32'hA0000001, 1);
    add(1, 1, 24'h100100, 24'h200004, 2, 32'hA0000002, 1);
    add(1, 1, 24'h100100, 24'h200008, 2, 32'hA0000003, 1);
    add(1, 1, 24'h100100, 24'h20000C, 2, 32'hC0000001, 0);
    add(1, 1, 24'h100104, 24'h20000C, 3, 32'hA0000004, 1);
    add(1, 1, 24'h100104, 24'h200010, 1, 32'hA0000005, 1);
    add(1, 1, 24'h100104, 24'h200014, 2, 32'hA0000006, 1);
    add(1, 1, 24'h100104, 24'h200018, 2, 32'hC0000002, 0);
    // Zero-wait flash
    add(0, 1, 24'h000000, 24'h250000, 1, 32'h0F0F0F0F, 1);
    add(1, 0, 24'h150000, 24'h000000, 1, 32'hF0F0F0F0, 0);
    // Uncontended audio reads leave the streak at zero
    for (int i = 0; i < 10; i++) begin
      add(0, 1, 24'h000000, 24'(24'h300000 + 4 * i), 1 + (i % 2), 32'h5A000000 + 32'(i), 1);
    end
    add(1, 1, 24'h100200, 24'h300040, 1, 32'hA0000010, 1);
    add(1, 1, 24'h100200, 24'h300044, 2, 32'hA0000011, 1);
    add(1, 1, 24'h100200, 24'h300048, 1, 32'hA0000012, 1);
    add(1, 1, 24'h100200, 24'h30004C, 2, 32'hC0000010, 0);

    tick();
    tick();
    reset_2x = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i);

    // Build streak to 2, start a third contended read, reset during ISSUE with a
    // simultaneous flash_ready, then send a stray flash_ready.
    h.cv = 1; h.av = 1; h.ca = 24'h100300; h.lat = 2; h.exp_aud = 1;
    h.aa = 24'h400000; h.data = 32'hB0000001; run_txn(h, 100);
    h.aa = 24'h400004; h.data = 32'hB0000002; run_txn(h, 101);
    audio_address = 24'h400008;
    tick();
    chk("rst grant", {31'd0, grant_audio}, 32'd1);
    chk("rst issue flash_valid", {31'd0, flash_valid}, 32'd1);
    tick();
    reset_2x = 1'b1; flash_ready = 1'b1; flash_rdata = 32'h12345678;
    cpu_valid = 1'b0; audio_valid = 1'b0;
    tick();
    reset_2x = 1'b0; flash_ready = 1'b0;
    exp_crd = 32'd0; exp_ard = 32'd0;
    chk_reset_vals("midreset");
    flash_ready = 1'b1;
    tick();
    flash_ready = 1'b0; flash_rdata = 32'd0;
    chk_reset_vals("stray");
    tick();
    chk_reset_vals("stray+1");

    // Streak must restart from zero after reset
    h.ca = 24'h100400;
    h.aa = 24'h500000; h.data = 32'hD0000001; h.exp_aud = 1; run_txn(h, 200);
    h.aa = 24'h500004; h.data = 32'hD0000002; h.exp_aud = 1; run_txn(h, 201);
    h.aa = 24'h500008; h.data = 32'hD0000003; h.exp_aud = 1; run_txn(h, 202);
    h.aa = 24'h50000C; h.data = 32'hD0000004; h.exp_aud = 0; run_txn(h, 203);
    cpu_valid = 1'b0; audio_valid = 1'b0;
    tick();
    chk("final busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Shares the single QSPI flash read port between two requesters: the CPU (instruction and data fetches from flash) and the ADPCM audio stream fetcher. It sits between those masters and the flash read controller that drives the flash pins. The block sequences one read at a time, latches the winning address, and routes the returned word back to its owner. Audio has priority because it is real-time, and a streak limit bounds how long the CPU can be starved.

## Interface

Parameters:
- `ADDR_WIDTH`, 24: flash byte address width.
- `AUDIO_STREAK_MAX`, 3: maximum consecutive contended audio grants before the CPU is forced in. Legal range is 1–15.

Ports:
- `clk_2x`  in  1  sole clock.
- `reset_2x`  in  1  synchronous, active-high reset.
- `cpu_valid`  in  1  CPU read request; held until `cpu_ready`.
- `cpu_address`  in  ADDR_WIDTH  CPU read address; stable while `cpu_valid`.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  read data; valid during `cpu_ready`, held afterwards.
- `audio_valid`  in  1  audio read request; held until `audio_ready`.
- `audio_address`  in  ADDR_WIDTH  audio read address.
- `audio_ready`  out  1  one-cycle completion pulse.
- `audio_rdata`  out  32  read data; valid during `audio_ready`, held afterwards.
- `flash_valid`  out  1  request to the flash controller; held until `flash_ready`.
- `flash_address`  out  ADDR_WIDTH  latched address; stable while `flash_valid`.
- `flash_ready`  in  1  one-cycle completion pulse from the flash controller.
- `flash_rdata`  in  32  flash data; valid during `flash_ready`.
- `grant_audio`  out  1  owner of the current or last transaction (1 = audio).
- `busy`  out  1  high in any state other than IDLE.

## Operation

- The FSM has three states: IDLE, ISSUE and RESPOND.

IDLE:
- If no request is valid, stay in IDLE.
- Otherwise pick a winner, latch its address into `flash_address`, set `grant_audio`, assert `flash_valid` from the next cycle, and go to ISSUE.

Arbitration in IDLE:
- If only one request is valid, that requester wins.
- If both are valid, audio wins unless `streak == AUDIO_STREAK_MAX`, in which case the CPU wins.
- `streak` is a 4-bit counter:
  - It increments on an audio grant made while `cpu_valid` is high.
  - It clears on any CPU grant.
  - An uncontended audio grant leaves it unchanged.
  - It saturates at `AUDIO_STREAK_MAX`.

ISSUE:
- Hold `flash_valid` and `flash_address` stable.
- On `flash_ready`:
  - Deassert `flash_valid`.
  - Register `flash_rdata` into the owner's `rdata` only; the other requester's `rdata` is unchanged.
  - Assert the owner's `ready` for the next cycle.
  - Go to RESPOND.

RESPOND:
- The owner's `ready` is high for exactly this one cycle.
- Request inputs are ignored; the FSM always returns to IDLE.

Requester contract:
- A requester deasserts `valid`, or presents a new address, in the cycle after its `ready`. This guarantees IDLE never re-grants a completed request.
- Changing the address or dropping `valid` before `ready` is illegal. The block keeps using the latched address and still delivers the response to the owner.

Other rules:
- `flash_ready` while `flash_valid` is low is ignored.
- At most one transaction is outstanding; there is no pipelining.

## Timing

- The request is sampled at edge 0. `flash_valid` is high from cycle 1.
- If `flash_ready` arrives in cycle k (k ≥ 1), the owner's `ready` is high in cycle k+1 and the FSM is back in IDLE in cycle k+2.
- The minimum turnaround is 3 cycles from grant to the next grant.
- Reset values:
  - state = IDLE, `streak` = 0.
  - `flash_valid`, `cpu_ready`, `audio_ready`, `grant_audio` and `busy` = 0.
  - `flash_address`, `cpu_rdata` and `audio_rdata` = 0.
- Reset mid-transaction abandons the read:
  - `flash_valid` drops in the cycle after reset is sampled, and no `ready` is issued for the abandoned read.
  - The flash controller shares `reset_2x` and aborts as well.
- `flash_ready` and `reset_2x` in the same cycle: reset wins, and neither `ready` pulses.
- A new request arriving during ISSUE or RESPOND waits for IDLE; its `valid` must stay high.

## Test plan

1. **CPU-only read.** Reset, then `cpu_valid` with address 0x100000; the flash model returns 0xDEADBEEF after 5 cycles. Required: `flash_address` = 0x100000, `flash_valid` high for cycles 1–5, `cpu_ready` pulses in cycle 6 with `cpu_rdata` = 0xDEADBEEF, and `audio_ready` never asserts.
2. **Contention with default streak.** Both requesters hold `valid` continuously and re-request immediately after each `ready`. Required grant order is A,A,A,C,A,A,A,C, and each `rdata` matches the data returned for its own address.
3. **Zero-wait flash.** `flash_ready` is returned in cycle 1. Required: owner `ready` in cycle 2, next grant at cycle 3, `busy` low only in the IDLE cycles.
4. **Reset mid-read.** Assert `reset_2x` for one cycle during ISSUE, then return a stray `flash_ready`. Required: all outputs return to reset values, no `ready` pulse occurs, and the stray `flash_ready` is ignored.
5. **Uncontended audio streak.** Issue 10 audio-only reads, then assert `cpu_valid` and `audio_valid` together. Required: audio is granted first (`streak` was 0), the CPU after three contended audio grants, and `cpu_rdata` holds its value through all audio transfers.
